sprite_motion_ctrl: RTL
=======================

// Module: sprite_motion_ctrl
// PURPOSE
//  Turns the four raw DE2 pushbuttons (moveUp/Down/Left/Right, active-low) into a sprite position.
//  Synchronises and debounces each button, then steps the position once per video frame.
//  Sits between the board keys and vga_controller; pos_x/pos_y feed the controller's sprite draw logic.
// PARAMETERS
//  SCREEN_W      640     visible width, pixels
//  SCREEN_H      480     visible height, pixels
//  SPRITE_W      32      sprite width, pixels
//  SPRITE_H      32      sprite height, pixels
//  STEP          4       pixels moved per frame per axis
//  DEBOUNCE_CYC  500000  consecutive stable cycles to accept a level change (10 ms @ 50 MHz)
//  X_INIT        304     reset x (top-left corner)
//  Y_INIT        224     reset y (top-left corner)
// PORTS
//  clock       in   1   system clock, same domain as frame_tick
//  resetn      in   1   asynchronous active-low reset
//  moveUp      in   1   raw key, 0 = pressed, asynchronous
//  moveDown    in   1   raw key, 0 = pressed, asynchronous
//  moveLeft    in   1   raw key, 0 = pressed, asynchronous
//  moveRight   in   1   raw key, 0 = pressed, asynchronous
//  frame_tick  in   1   one-cycle pulse per frame, at the start of vertical blank
//  pos_x       out  10  sprite left edge, 0..SCREEN_W-SPRITE_W
//  pos_y       out  10  sprite top edge, 0..SCREEN_H-SPRITE_H
//  btn_held    out  4   debounced pressed state {up,down,left,right}, 1 = pressed
//  moved       out  1   one-cycle pulse when pos_x or pos_y changed
// BEHAVIOUR
//  Reset (async assert, sync release):
//   pos_x=X_INIT, pos_y=Y_INIT, btn_held=0, moved=0.
//   Synchroniser flops preset to 1 (released); debounce counters cleared.
//  Input path, per key:
//   - 2-FF synchroniser.
//   - Debounce counter (ceil(log2(DEBOUNCE_CYC+1)) bits). Counts while the synced level differs
//     from the accepted level. Clears whenever the levels match.
//   - Reaching DEBOUNCE_CYC updates the accepted level and clears the counter.
//   - btn_held = ~accepted level. Raw edge to btn_held change = 2 + DEBOUNCE_CYC + 1 cycles.
//   - A glitch shorter than DEBOUNCE_CYC cycles never changes btn_held.
//  Motion, evaluated only in the cycle frame_tick=1, using btn_held sampled that cycle:
//   - dx = +STEP if right only, -STEP if left only, 0 if neither or both. dy likewise: down=+, up=-.
//   - Axes are independent; diagonal motion is allowed.
//   - New pos_x/pos_y are registered on the cycle after frame_tick (latency 1).
//   - moved pulses in that same cycle iff either coordinate changed.
//   - Arithmetic is 11-bit signed to detect under/overflow before the limit check.
//   - Keys held across many frames move STEP per frame; no acceleration.
//   - frame_tick on consecutive cycles: each tick is evaluated; no tick is dropped.
//  Edge handling (default, clamp):
//   - x+dx < 0 -> pos_x = 0.
//   - x+dx > SCREEN_W-SPRITE_W -> pos_x = SCREEN_W-SPRITE_W. Same rule for y.
//   - Pressing into a limit while already at it leaves the position unchanged; moved stays 0.
//  Reset mid-operation: all state returns to reset values immediately; pending debounce counts are lost.
// CONFIGURATION
//  SPRITE_WRAP_EN defined:
//   - Overrun past the max limit -> coordinate = 0. Underrun below 0 -> coordinate = max limit
//     (SCREEN_W-SPRITE_W or SCREEN_H-SPRITE_H).
//   - moved pulses on a wrap.
//  SPRITE_WRAP_EN undefined: clamp behaviour above; no wrap logic synthesised.
// TESTING  (sim with DEBOUNCE_CYC=4)
//  1. Reset: release resetn -> pos=(304,224), btn_held=0, moved=0; frame_tick with no keys -> no change, moved=0.
//  2. Debounce: moveRight low for 3 cycles then high -> btn_held stays 0.
//     Held low -> btn_held[0]=1 exactly 7 cycles after the edge.
//  3. Motion: right held, 3 frame_ticks -> pos_x=316, one moved pulse per tick.
//     Left+right held -> pos_x unchanged. Up+right held -> (x+4, y-4).
//  4. Clamp: pos_x=606, right held, tick -> pos_x=608. Next tick -> 608, moved=0.
//     pos_y=2, up held, tick -> pos_y=0.
//  5. Wrap (SPRITE_WRAP_EN): pos_x=606, right, tick -> pos_x=0. pos_y=0, up, tick -> pos_y=448. moved=1 both.
//  6. Async reset while right held and mid-debounce -> pos=(304,224) within the same cycle, btn_held=0.
//     After release, the key needs a full re-debounce before motion resumes.

Source files
------------

// File: rtl/sprite_motion_ctrl_if.sv
// Purpose: bundles the raw key inputs, frame tick and sprite position outputs of sprite_motion_ctrl.
// Latency: none (wires only).
// Backpressure: none; keys are levels and frame_tick is a single-cycle pulse.
interface sprite_motion_ctrl_if;
    logic       moveUp;
    logic       moveDown;
    logic       moveLeft;
    logic       moveRight;
    logic       frame_tick;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [3:0] btn_held;
    logic       moved;

    // Driver side: board keys plus the video timing tick; observes the sprite position.
    modport master (
        output moveUp,
        output moveDown,
        output moveLeft,
        output moveRight,
        output frame_tick,
        input  pos_x,
        input  pos_y,
        input  btn_held,
        input  moved
    );

    // Motion controller side.
    modport slave (
        input  moveUp,
        input  moveDown,
        input  moveLeft,
        input  moveRight,
        input  frame_tick,
        output pos_x,
        output pos_y,
        output btn_held,
        output moved
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Purpose: sync + debounce four active-low keys and step a sprite position once per frame (macro SPRITE_WRAP_EN selects wrap instead of clamp at the screen edges).
// Latency: key edge to btn_held = 2 + DEBOUNCE_CYC + 1 cycles; frame_tick to pos_x/pos_y/moved = 1 cycle.
// Backpressure: none; every frame_tick is evaluated, including ticks on consecutive cycles.
module sprite_motion_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int SPRITE_W     = 32,
    parameter int SPRITE_H     = 32,
    parameter int STEP         = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int X_INIT       = 304,
    parameter int Y_INIT       = 224
) (
    input  logic               clock,
    input  logic               resetn,
    sprite_motion_ctrl_if.slave io
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int X_MAX = SCREEN_W - SPRITE_W;
    localparam int Y_MAX = SCREEN_H - SPRITE_H;

    localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
    localparam logic signed [10:0] ZERO_S   = 11'sd0;
    localparam logic [9:0]         X_MAX_10 = 10'(X_MAX);
    localparam logic [9:0]         Y_MAX_10 = 10'(Y_MAX);
    localparam logic [9:0]         X_INIT_10 = 10'(X_INIT);
    localparam logic [9:0]         Y_INIT_10 = 10'(Y_INIT);

    // Key order everywhere below: {up, down, left, right}, matching btn_held.
    logic [3:0]            key_raw;
    logic [3:0]            key_meta;
    logic [3:0]            key_sync;
    logic [3:0]            key_accepted;   // debounced level, 0 = pressed
    logic [3:0][CNT_W-1:0] db_cnt;

    logic                  rst_meta;
    logic                  rst_sync_n;

    logic [9:0]            pos_x_q;
    logic [9:0]            pos_y_q;
    logic                  moved_q;
    logic [3:0]            held;

    logic signed [10:0]    dx;
    logic signed [10:0]    dy;
    logic signed [10:0]    sum_x;
    logic signed [10:0]    sum_y;
    logic [9:0]            next_x;
    logic [9:0]            next_y;

    assign key_raw = {io.moveUp, io.moveDown, io.moveLeft, io.moveRight};
    assign held    = ~key_accepted;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Two-flop synchroniser per key; presets to released so reset never looks like a press.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
        end
    end

    // Debounce: a level change is accepted only after it has persisted past DEBOUNCE_CYC counts.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            key_accepted <= 4'hF;
            db_cnt       <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_sync[i] == key_accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_DONE) begin
                    key_accepted[i] <= key_sync[i];
                    db_cnt[i]       <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Candidate next position: opposing keys cancel, then the edge policy is applied per axis.
    always_comb begin
        dx = ZERO_S;
        dy = ZERO_S;
        if (held[0] && !held[1]) begin
            dx = STEP_S;
        end else if (held[1] && !held[0]) begin
            dx = -STEP_S;
        end
        if (held[2] && !held[3]) begin
            dy = STEP_S;
        end else if (held[3] && !held[2]) begin
            dy = -STEP_S;
        end

        // 11-bit signed sums keep underflow visible as a negative value.
        sum_x = $signed({1'b0, pos_x_q}) + dx;
        sum_y = $signed({1'b0, pos_y_q}) + dy;

`ifdef SPRITE_WRAP_EN
        if (sum_x < ZERO_S) begin
            next_x = X_MAX_10;
        end else if (sum_x > X_MAX_S) begin
            next_x = '0;
        end else begin
            next_x = sum_x[9:0];
        end
        if (sum_y < ZERO_S) begin
            next_y = Y_MAX_10;
        end else if (sum_y > Y_MAX_S) begin
            next_y = '0;
        end else begin
            next_y = sum_y[9:0];
        end
`else
        if (sum_x < ZERO_S) begin
            next_x = '0;
        end else if (sum_x > X_MAX_S) begin
            next_x = X_MAX_10;
        end else begin
            next_x = sum_x[9:0];
        end
        if (sum_y < ZERO_S) begin
            next_y = '0;
        end else if (sum_y > Y_MAX_S) begin
            next_y = Y_MAX_10;
        end else begin
            next_y = sum_y[9:0];
        end
`endif
    end

    // Position register: commits only on frame_tick; moved flags an actual change.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pos_x_q <= X_INIT_10;
            pos_y_q <= Y_INIT_10;
            moved_q <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            if (io.frame_tick) begin
                pos_x_q <= next_x;
                pos_y_q <= next_y;
                moved_q <= (next_x != pos_x_q) || (next_y != pos_y_q);
            end
        end
    end

    assign io.pos_x    = pos_x_q;
    assign io.pos_y    = pos_y_q;
    assign io.btn_held = held;
    assign io.moved    = moved_q;

endmodule
